usb_bus_turnaround_ctrl: RTL and testbench

USB_BUS_TURNAROUND_CTRL -- requirements
Module: usb_bus_turnaround_ctrl

---
 rtl/usb_bus_turnaround_ctrl.sv | 119 +++++++++++
 tb/tb_usb_bus_turnaround_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_turnaround_ctrl.sv
// USB half-duplex bus turnaround controller: arbitrates direction between the
// receiver and transmitter, enforcing inter-packet gaps and a TX watchdog.
`timescale 1ns/1ps
module usb_bus_turnaround_ctrl #(
   parameter int unsigned GAP_CYCLES     = 8,
   parameter int unsigned RELEASE_CYCLES = 2,
   parameter int unsigned TX_MAX         = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_active,
   input  logic rx_eop,
   input  logic tx_request,
   input  logic tx_done,
   output logic transmitting,
   output logic tx_start,
   output logic tx_error,
   output logic busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX,
      S_GAP,
      S_SETUP,
      S_TX,
      S_RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Outputs are registered alongside the state so each one is a flop that
   // mirrors the state being entered; reset clears them without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         transmitting <= 1'b0;
         tx_start     <= 1'b0;
         tx_error     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_active) begin
                  state <= S_RX;
                  busy  <= 1'b1;
               end else if (tx_request) begin
                  state        <= S_SETUP;
                  busy         <= 1'b1;
                  transmitting <= 1'b1;
               end
            end
            S_RX: begin
               if (rx_eop) begin
                  state <= S_GAP;
                  cnt   <= '0;
               end else if (!rx_active) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_GAP: begin
               if (rx_active) begin
                  state <= S_RX;
               end else if (cnt == GAP_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_SETUP: begin
               state    <= S_TX;
               cnt      <= '0;
               tx_start <= 1'b1;
            end
            // Echo of our own packet on rx_active/rx_eop is ignored here.
            S_TX: begin
               if (tx_done) begin
                  state <= S_RELEASE;
                  cnt   <= '0;
               end else if (cnt == TX_LAST) begin
                  state    <= S_RELEASE;
                  cnt      <= '0;
                  tx_error <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_RELEASE: begin
               if (cnt == REL_LAST) begin
                  state        <= S_GAP;
                  cnt          <= '0;
                  transmitting <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state        <= S_IDLE;
               cnt          <= '0;
               transmitting <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_bus_turnaround_ctrl.sv
// Self-checking bench for usb_bus_turnaround_ctrl: directed turnaround scenarios
// followed by randomized traffic, all checked against a phase/countdown model.
`timescale 1ns/1ps
module tb_usb_bus_turnaround_ctrl;

   localparam int unsigned GAP = 8;
   localparam int unsigned REL = 2;
   localparam int unsigned TXM = 16;

   logic clk = 1'b0;
   logic reset;
   logic rx_active, rx_eop, tx_request, tx_done;
   logic transmitting, tx_start, tx_error, busy;

   usb_bus_turnaround_ctrl #(
      .GAP_CYCLES(GAP), .RELEASE_CYCLES(REL), .TX_MAX(TXM), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .rx_active(rx_active), .rx_eop(rx_eop),
      .tx_request(tx_request), .tx_done(tx_done), .transmitting(transmitting),
      .tx_start(tx_start), .tx_error(tx_error), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model phases; each phase carries its own remaining-cycle countdown.
   localparam int P_IDLE = 0, P_RX = 1, P_GAP = 2, P_SETUP = 3, P_TX = 4, P_REL = 5;
   int m_phase, m_left, m_age;
   bit m_start, m_err;

   int n_checks = 0, n_errors = 0;
   int n_txhi = 0, n_start = 0, n_err = 0, n_busy = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_left = 0; m_age = 0; m_start = 0; m_err = 0;
   endtask

   task automatic model_step();
      m_start = 0;
      m_err   = 0;
      case (m_phase)
         P_IDLE:  if (rx_active) m_phase = P_RX;
                  else if (tx_request) m_phase = P_SETUP;
         P_RX:    if (rx_eop) begin m_phase = P_GAP; m_left = GAP; end
                  else if (!rx_active) m_phase = P_IDLE;
         P_GAP:   if (rx_active) m_phase = P_RX;
                  else begin
                     m_left--;
                     if (m_left == 0) m_phase = P_IDLE;
                  end
         P_SETUP: begin m_phase = P_TX; m_age = 0; m_start = 1; end
         P_TX: begin
            m_age++;
            if (tx_done) begin m_phase = P_REL; m_left = REL; end
            else if (m_age == TXM) begin m_phase = P_REL; m_left = REL; m_err = 1; end
         end
         P_REL: begin
            m_left--;
            if (m_left == 0) begin m_phase = P_GAP; m_left = GAP; end
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   // One clock: model advances on the edge, all outputs compared on the falling edge.
   task automatic cyc();
      logic exp_tx, exp_busy;
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
      exp_tx   = (m_phase == P_SETUP) || (m_phase == P_TX) || (m_phase == P_REL);
      exp_busy = (m_phase != P_IDLE);
      chk("transmitting", transmitting, exp_tx);
      chk("busy", busy, exp_busy);
      chk("tx_start", tx_start, m_start);
      chk("tx_error", tx_error, m_err);
      n_txhi  += int'(transmitting);
      n_start += int'(tx_start);
      n_err   += int'(tx_error);
      n_busy  += int'(busy);
      #1;
   endtask

   task automatic drain_idle(input int max_cycles);
      int k = 0;
      while (busy && k < max_cycles) begin
         cyc();
         k++;
      end
      chk("drain_to_idle", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int s_tx, s_st, s_err, s_busy;
      reset = 1'b1; rx_active = 0; rx_eop = 0; tx_request = 0; tx_done = 0;
      model_reset();
      @(negedge clk);
      chk("rst_transmitting", transmitting, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_error", tx_error, 1'b0);
      #1 reset = 1'b0;
      repeat (2) cyc();

      // Idle TX, 10-cycle packet
      s_tx = n_txhi; s_st = n_start; s_err = n_err; s_busy = n_busy;
      tx_request = 1;
      cyc();
      chk("s1_setup_transmitting", transmitting, 1'b1);
      chk("s1_setup_no_start", tx_start, 1'b0);
      cyc();
      chk("s1_start_latency2", tx_start, 1'b1);
      tx_request = 0;
      repeat (9) cyc();
      tx_done = 1; cyc(); tx_done = 0;
      chk("s1_release_transmitting", transmitting, 1'b1);
      drain_idle(40);
      chk_int("s1_transmitting_cycles", n_txhi - s_tx, 13);
      chk_int("s1_start_pulses", n_start - s_st, 1);
      chk_int("s1_error_pulses", n_err - s_err, 0);
      chk_int("s1_busy_cycles", n_busy - s_busy, 21);

      // Simultaneous rx_active and tx_request
      rx_active = 1; tx_request = 1;
      cyc();
      chk("s2_rx_wins_transmitting", transmitting, 1'b0);
      chk("s2_rx_busy", busy, 1'b1);
      rx_eop = 1; cyc(); rx_eop = 0; rx_active = 0;
      repeat (8) cyc();
      chk("s2_gap_done_idle", busy, 1'b0);
      cyc();
      chk("s2_setup_after_gap", transmitting, 1'b1);
      tx_request = 0;
      cyc();
      chk("s2_start", tx_start, 1'b1);
      tx_done = 1; cyc(); tx_done = 0;
      drain_idle(40);

      // Gap interrupted on cycle 5, then aborted RX
      s_st = n_start;
      rx_active = 1; cyc();
      rx_eop = 1; cyc(); rx_eop = 0; rx_active = 0; tx_request = 1;
      repeat (4) cyc();
      rx_active = 1; cyc();
      chk("s3_rx_reentered_busy", busy, 1'b1);
      chk("s3_rx_not_transmitting", transmitting, 1'b0);
      rx_active = 0; tx_request = 0; cyc();
      chk("s3_abort_idle", busy, 1'b0);
      chk_int("s3_no_start", n_start - s_st, 0);

      // Watchdog expiry
      s_tx = n_txhi; s_err = n_err;
      tx_request = 1; cyc(); cyc(); tx_request = 0;
      repeat (15) cyc();
      chk("s4_tx16_no_error", tx_error, 1'b0);
      cyc();
      chk("s4_error_pulse", tx_error, 1'b1);
      chk("s4_error_transmitting", transmitting, 1'b1);
      cyc();
      chk("s4_error_single", tx_error, 1'b0);
      chk("s4_release2_transmitting", transmitting, 1'b1);
      cyc();
      chk("s4_bus_released", transmitting, 1'b0);
      chk("s4_gap_busy", busy, 1'b1);
      drain_idle(40);
      chk_int("s4_transmitting_cycles", n_txhi - s_tx, 19);
      chk_int("s4_error_pulses", n_err - s_err, 1);

      // Echo rejection during TX
      tx_request = 1; cyc(); cyc(); tx_request = 0;
      rx_active = 1; rx_eop = 1; cyc(); rx_eop = 0; cyc(); rx_active = 0;
      chk("s5_echo_transmitting", transmitting, 1'b1);
      tx_done = 1; cyc(); tx_done = 0;
      chk("s5_rel1", transmitting, 1'b1);
      cyc();
      chk("s5_rel2", transmitting, 1'b1);
      cyc();
      chk("s5_gap", transmitting, 1'b0);
      drain_idle(40);

      // Asynchronous reset in the middle of TX
      tx_request = 1; cyc(); cyc(); tx_request = 0; cyc();
      reset = 1'b1;
      #1;
      chk("s6_async_transmitting", transmitting, 1'b0);
      chk("s6_async_busy", busy, 1'b0);
      chk("s6_async_error", tx_error, 1'b0);
      model_reset();
      #1 reset = 1'b0;
      repeat (3) cyc();
      chk("s6_stays_idle", busy, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) rx_active = ~rx_active;
         rx_eop  = ($urandom_range(9) == 0);
         tx_done = ($urandom_range(11) == 0);
         if ($urandom_range(5) == 0) tx_request = ~tx_request;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
